// File: rtl/eth_pkg.sv
// Shared types and MDIO framing constants for the Ethernet PHY manager.
// Both the controller and the MDIO shifter import this package.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_RST_HOLD,
      ST_RST_WAIT,
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_TA_WR = 2'b10;
   localparam logic [4:0] BMSR_ADDR  = 5'd1;
   localparam int         LINK_BIT   = 2;
   localparam int         FRAME_LEN  = 64;
   localparam int         RD_OE_BITS = 46;

   // Full 64-bit clause-22 frame; read frames carry ones in TA/data.
   function automatic logic [63:0] mdio_frame(
      input logic        we,
      input logic [4:0]  phyad,
      input logic [4:0]  regad,
      input logic [15:0] wdata
   );
      if (we)
         return {32'hFFFF_FFFF, MDIO_ST, MDIO_OP_WR,
                 phyad, regad, MDIO_TA_WR, wdata};
      return {32'hFFFF_FFFF, MDIO_ST, MDIO_OP_RD,
              phyad, regad, 2'b11, 16'hFFFF};
   endfunction

endpackage

// File: rtl/mdio_shifter.sv
// MDC divider and 64-bit MDIO shift/sample engine.
// mdio_o moves on MDC fall, mdio_i is sampled on MDC rise.
module mdio_shifter
   import eth_pkg::*;
#(
   parameter int CLK_DIV = 25
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        rd_mode,
   input  logic [63:0] frame,
   input  logic        mdio_i,
   output logic        done,
   output logic [15:0] rdata,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic          active_q, active_d;
   logic [DW-1:0] div_q, div_d;
   logic [5:0]    bit_q, bit_d;
   logic [63:0]   sh_q, sh_d;
   logic          rd_q, rd_d;
   logic [15:0]   dat_q, dat_d;
   logic          mdc_q, mdc_d;
   logic          oe_q, oe_d;
   logic          tick;

   assign tick    = (div_q == DW'(CLK_DIV - 1));
   assign done    = active_q & tick & mdc_q &
                    (bit_q == 6'(FRAME_LEN - 1));
   assign rdata   = dat_q;
   assign mdc     = mdc_q;
   assign mdio_o  = active_q ? sh_q[63] : 1'b1;
   assign mdio_oe = oe_q;

   // Half-period timing, bit advance on fall, data capture on rise.
   always_comb begin
      active_d = active_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      rd_d     = rd_q;
      dat_d    = dat_q;
      mdc_d    = mdc_q;
      oe_d     = oe_q;
      if (start && !active_q) begin
         active_d = 1'b1;
         div_d    = '0;
         bit_d    = '0;
         sh_d     = frame;
         rd_d     = rd_mode;
         dat_d    = '0;
         mdc_d    = 1'b0;
         oe_d     = 1'b1;
      end else if (active_q) begin
         if (tick) begin
            div_d = '0;
            if (!mdc_q) begin
               mdc_d = 1'b1;
               if (rd_q && bit_q >= 6'd48)
                  dat_d = {dat_q[14:0], mdio_i};
            end else begin
               mdc_d = 1'b0;
               if (bit_q == 6'(FRAME_LEN - 1)) begin
                  active_d = 1'b0;
                  oe_d     = 1'b0;
               end else begin
                  bit_d = bit_q + 6'd1;
                  sh_d  = {sh_q[62:0], 1'b1};
                  oe_d  = !rd_q || (bit_d < 6'(RD_OE_BITS));
               end
            end
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   // Engine state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '1;
         rd_q     <= 1'b0;
         dat_q    <= '0;
         mdc_q    <= 1'b0;
         oe_q     <= 1'b0;
      end else begin
         active_q <= active_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         rd_q     <= rd_d;
         dat_q    <= dat_d;
         mdc_q    <= mdc_d;
         oe_q     <= oe_d;
      end
   end

endmodule

// File: rtl/eth_phy_mgmt.sv
// Ethernet PHY manager: reset sequencing, host MDIO access
// and periodic BMSR link polling sharing one MDIO bus.
module eth_phy_mgmt
   import eth_pkg::*;
#(
   parameter int ETHCOUNT      = 4,
   parameter int CLK_DIV       = 25,
   parameter int RST_HOLD      = 1250000,
   parameter int RST_WAIT      = 625000,
   parameter int POLL_CYCLES   = 12500000,
   parameter int PHY_ADDR_BASE = 0
)(
   input  logic                p_in_clk,
   input  logic                p_in_rst,
   input  logic                req,
   input  logic                req_we,
   input  logic [1:0]          req_phy,
   input  logic [4:0]          req_reg,
   input  logic [15:0]         req_wdata,
   output logic                ack,
   output logic                ack_err,
   output logic [15:0]         rdata,
   output logic [ETHCOUNT-1:0] link_up,
   output logic [ETHCOUNT-1:0] eth_phy_rst,
   output logic                mdc,
   output logic                mdio_o,
   output logic                mdio_oe,
   input  logic                mdio_i,
   output logic                busy
);

   state_e              state_q, state_d;
   logic [31:0]         rcnt_q, rcnt_d;
   logic [31:0]         pcnt_q, pcnt_d;
   logic                tmr_en_q, tmr_en_d;
   logic                pend_q, pend_d;
   logic [1:0]          pidx_q, pidx_d;
   logic                ptr_host_q, ptr_host_d;
   logic                cur_poll_q, cur_poll_d;
   logic                cur_we_q, cur_we_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [15:0]         rdata_q, rdata_d;
   logic [ETHCOUNT-1:0] link_q, link_d;
   logic                prst_q, prst_d;

   logic        sh_start, sh_rd, sh_done;
   logic [63:0] sh_frame;
   logic [15:0] sh_rdata;
   logic        grant_host, phy_bad;

   function automatic logic [4:0] phy_addr(input logic [1:0] idx);
      return 5'(PHY_ADDR_BASE) + {3'b000, idx};
   endfunction

   assign grant_host  = req && (!pend_q || ptr_host_q);
   assign phy_bad     = ({30'd0, req_phy} >= 32'(ETHCOUNT));
   assign ack         = ack_q;
   assign ack_err     = err_q;
   assign rdata       = rdata_q;
   assign link_up     = link_q;
   assign eth_phy_rst = {ETHCOUNT{prst_q}};
   assign busy        = (state_q != ST_IDLE);

   mdio_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk     (p_in_clk),
      .rst     (p_in_rst),
      .start   (sh_start),
      .rd_mode (sh_rd),
      .frame   (sh_frame),
      .mdio_i  (mdio_i),
      .done    (sh_done),
      .rdata   (sh_rdata),
      .mdc     (mdc),
      .mdio_o  (mdio_o),
      .mdio_oe (mdio_oe)
   );

   // Next-state: reset sequence, arbitration, frame completion, poll timer.
   always_comb begin
      state_d    = state_q;
      rcnt_d     = rcnt_q;
      pcnt_d     = pcnt_q;
      tmr_en_d   = tmr_en_q;
      pend_d     = pend_q;
      pidx_d     = pidx_q;
      ptr_host_d = ptr_host_q;
      cur_poll_d = cur_poll_q;
      cur_we_d   = cur_we_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rdata_d    = rdata_q;
      link_d     = link_q;
      sh_start   = 1'b0;
      sh_rd      = 1'b0;
      sh_frame   = '1;
      unique case (state_q)
         ST_RST_HOLD: begin
            if (rcnt_q == 32'(RST_HOLD - 1)) begin
               rcnt_d  = '0;
               state_d = ST_RST_WAIT;
            end else begin
               rcnt_d = rcnt_q + 32'd1;
            end
         end
         ST_RST_WAIT: begin
            if (rcnt_q == 32'(RST_WAIT - 1)) begin
               rcnt_d  = '0;
               state_d = ST_IDLE;
            end else begin
               rcnt_d = rcnt_q + 32'd1;
            end
         end
         ST_IDLE: begin
            if (grant_host) begin
               ptr_host_d = 1'b0;
               cur_poll_d = 1'b0;
               cur_we_d   = req_we;
               if (phy_bad) begin
                  state_d = ST_DONE;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  rdata_d = 16'hFFFF;
               end else begin
                  sh_start = 1'b1;
                  sh_rd    = ~req_we;
                  sh_frame = mdio_frame(req_we, phy_addr(req_phy),
                                        req_reg, req_wdata);
                  state_d  = ST_SHIFT;
               end
            end else if (pend_q) begin
               ptr_host_d = 1'b1;
               cur_poll_d = 1'b1;
               sh_start   = 1'b1;
               sh_rd      = 1'b1;
               sh_frame   = mdio_frame(1'b0, phy_addr(pidx_q),
                                       BMSR_ADDR, 16'h0000);
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sh_done) begin
               state_d = ST_DONE;
               if (cur_poll_q) begin
                  for (int i = 0; i < ETHCOUNT; i++)
                     if (pidx_q == 2'(i))
                        link_d[i] = sh_rdata[LINK_BIT];
               end else begin
                  ack_d = 1'b1;
                  if (!cur_we_q)
                     rdata_d = sh_rdata;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (cur_poll_q) begin
               if (pidx_q == 2'(ETHCOUNT - 1)) begin
                  pidx_d = '0;
                  pend_d = 1'b0;
                  pcnt_d = '0;
               end else begin
                  pidx_d = pidx_q + 2'd1;
               end
            end
         end
         default: state_d = ST_RST_HOLD;
      endcase
      if (state_d == ST_IDLE)
         tmr_en_d = 1'b1;
      if (tmr_en_q && !pend_q) begin
         if (pcnt_q == 32'(POLL_CYCLES - 1)) begin
            pend_d = 1'b1;
            pcnt_d = '0;
         end else begin
            pcnt_d = pcnt_q + 32'd1;
         end
      end
      prst_d = (state_d == ST_RST_HOLD);
   end

   // Controller state and registered outputs.
   always_ff @(posedge p_in_clk or posedge p_in_rst) begin
      if (p_in_rst) begin
         state_q    <= ST_RST_HOLD;
         rcnt_q     <= '0;
         pcnt_q     <= '0;
         tmr_en_q   <= 1'b0;
         pend_q     <= 1'b0;
         pidx_q     <= '0;
         ptr_host_q <= 1'b1;
         cur_poll_q <= 1'b0;
         cur_we_q   <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         link_q     <= '0;
         prst_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         rcnt_q     <= rcnt_d;
         pcnt_q     <= pcnt_d;
         tmr_en_q   <= tmr_en_d;
         pend_q     <= pend_d;
         pidx_q     <= pidx_d;
         ptr_host_q <= ptr_host_d;
         cur_poll_q <= cur_poll_d;
         cur_we_q   <= cur_we_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         link_q     <= link_d;
         prst_q     <= prst_d;
      end
   end

endmodule

// File: tb/tb_eth_phy_mgmt.sv
// Bench for eth_phy_mgmt: PHY model on MDIO, ack scoreboard,
// reset sequencing, polling, out-of-range access, mid-frame reset.
`timescale 1ns/1ps
module tb_eth_phy_mgmt;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_phy = 2'd0;
   logic [4:0]  req_reg = 5'd0;
   logic [15:0] req_wdata = 16'h0;
   logic        ack, ack_err, mdc, mdio_o, mdio_oe, busy;
   logic [15:0] rdata;
   logic [3:0]  link_up, eth_phy_rst;
   logic        mdio_i = 1'b1;

   logic        rst2 = 1'b1;
   logic        req2 = 1'b0;
   logic        ack2, ack_err2, mdc2, mdio_o2, mdio_oe2, busy2;
   logic [15:0] rdata2;
   logic [2:0]  link_up2, eth_phy_rst2;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #4 clk = ~clk;

   eth_phy_mgmt #(
      .ETHCOUNT(4), .CLK_DIV(2), .RST_HOLD(20),
      .RST_WAIT(10), .POLL_CYCLES(2000), .PHY_ADDR_BASE(0)
   ) dut (
      .p_in_clk(clk), .p_in_rst(rst), .req(req), .req_we(req_we),
      .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
      .ack(ack), .ack_err(ack_err), .rdata(rdata), .link_up(link_up),
      .eth_phy_rst(eth_phy_rst), .mdc(mdc), .mdio_o(mdio_o),
      .mdio_oe(mdio_oe), .mdio_i(mdio_i), .busy(busy)
   );

   eth_phy_mgmt #(
      .ETHCOUNT(3), .CLK_DIV(2), .RST_HOLD(20),
      .RST_WAIT(10), .POLL_CYCLES(100000), .PHY_ADDR_BASE(0)
   ) dut2 (
      .p_in_clk(clk), .p_in_rst(rst2), .req(req2), .req_we(1'b0),
      .req_phy(2'd3), .req_reg(5'd1), .req_wdata(16'h0),
      .ack(ack2), .ack_err(ack_err2), .rdata(rdata2),
      .link_up(link_up2), .eth_phy_rst(eth_phy_rst2), .mdc(mdc2),
      .mdio_o(mdio_o2), .mdio_oe(mdio_oe2), .mdio_i(1'b1),
      .busy(busy2)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   // PHY model: register file, frame capture on MDC rise
   logic [15:0] phy_reg [0:3][0:31];
   int          bitcnt = 0;
   int          mdc_rises = 0;
   int          mdc2_rises = 0;
   logic [63:0] cap = '0, capoe = '0;
   logic [63:0] last_frame = '0, last_oe = '0;
   logic        f_rd = 1'b0;
   logic [4:0]  f_phy = '0, f_reg = '0;

   always @(posedge mdc or posedge rst) begin
      if (rst) begin
         bitcnt = 0;
      end else begin
         mdc_rises++;
         cap   = {cap[62:0], mdio_o};
         capoe = {capoe[62:0], mdio_oe};
         bitcnt++;
         if (bitcnt == 46) begin
            f_rd  = (cap[11:10] == 2'b10);
            f_phy = cap[9:5];
            f_reg = cap[4:0];
         end
         if (bitcnt == 64) begin
            last_frame = cap;
            last_oe    = capoe;
            bitcnt     = 0;
         end
      end
   end

   // PHY drives read data after MDC fall; PHY 3 is absent (pull-up)
   always @(negedge mdc or posedge rst) begin
      if (rst)
         mdio_i = 1'b1;
      else if (f_rd && bitcnt >= 48 && f_phy < 5'd3)
         mdio_i = phy_reg[f_phy][f_reg][15 - (bitcnt - 48)];
      else
         mdio_i = 1'b1;
   end

   always @(posedge mdc2) mdc2_rises++;

   // Scoreboard of expected host responses
   typedef struct {
      logic        err;
      logic [15:0] rd;
      int          lat;
   } exp_t;
   exp_t sb[$];
   int   acc_cyc = 0;
   logic busy_p = 1'b1;

   always @(negedge clk) begin
      if (busy && !busy_p) acc_cyc = cyc;
      busy_p = busy;
      if (ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_err", ack_err, e.err);
            chk("ack_rdata", rdata, e.rd);
            chk("ack_latency", cyc - acc_cyc, e.lat);
         end
      end
   end

   task automatic host(input logic we, input logic [1:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd,
                       input logic [15:0] erd);
      exp_t e;
      int   k;
      e.err = 1'b0;
      e.rd  = erd;
      e.lat = 256;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b1; req_we = we; req_phy = phy;
      req_reg = rg; req_wdata = wd;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ack && k < 2000);
      chk("host_ack_seen", ack, 1);
      req = 1'b0; req_we = 1'b0; req_wdata = 16'h0;
   endtask

   task automatic reset_seq(input string tag);
      int hold, bsy, r0;
      hold = 0;
      bsy  = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      r0 = mdc_rises;
      repeat (40) begin
         @(negedge clk);
         if (eth_phy_rst == 4'hF) hold++;
         if (busy) bsy++;
      end
      chk({tag, "_phy_rst_cycles"}, hold, 20);
      chk({tag, "_busy_cycles"}, bsy, 30);
      chk({tag, "_no_early_mdc"}, mdc_rises - r0, 0);
   endtask

   initial begin
      int k;
      for (int p = 0; p < 4; p++)
         for (int r = 0; r < 32; r++)
            phy_reg[p][r] = 16'hFFFF;
      phy_reg[0][1] = 16'h796D;
      phy_reg[1][1] = 16'h7949;
      phy_reg[2][1] = 16'h796D;
      phy_reg[2][2] = 16'h0141;

      repeat (3) @(negedge clk);
      chk("rst_phy_rst", eth_phy_rst, 4'hF);
      chk("rst_mdc", mdc, 0);
      chk("rst_mdio_oe", mdio_oe, 0);
      chk("rst_mdio_o", mdio_o, 1);
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_link", link_up, 0);
      chk("rst_busy", busy, 1);

      rst2 = 1'b0;
      reset_seq("first");

      // Out-of-range PHY on the 3-PHY instance
      @(negedge clk);
      req2 = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ack2 && k < 20);
      req2 = 1'b0;
      chk("err_ack_seen", ack2, 1);
      chk("err_ack_latency", k, 1);
      chk("err_ack_err", ack_err2, 1);
      chk("err_rdata", rdata2, 16'hFFFF);
      @(negedge clk);
      chk("err_ack_one_cycle", ack2, 0);
      repeat (4) @(negedge clk);
      chk("err_no_mdc", mdc2_rises, 0);

      host(1'b1, 2'd1, 5'd0, 16'h1140, 16'h0000);
      chk("wr_frame", last_frame, 64'hFFFF_FFFF_5082_1140);
      chk("wr_oe", last_oe, 64'hFFFF_FFFF_FFFF_FFFF);

      host(1'b0, 2'd2, 5'd2, 16'h0000, 16'h0141);
      chk("rd_header", last_frame[63:18],
          {32'hFFFF_FFFF, 14'b01_10_00010_00010});
      chk("rd_oe", last_oe, 64'hFFFF_FFFF_FFFC_0000);

      host(1'b0, 2'd3, 5'd1, 16'h0000, 16'hFFFF);
      host(1'b1, 2'd0, 5'd0, 16'h8000, 16'hFFFF);
      host(1'b0, 2'd0, 5'd1, 16'h0000, 16'h796D);
      chk("host_bmsr_no_link", link_up, 4'b0000);

      while (cyc < 2100) @(negedge clk);
      host(1'b0, 2'd1, 5'd1, 16'h0000, 16'h7949);

      while (cyc < 3400) @(negedge clk);
      chk("poll_link_up", link_up, 4'b1101);

      // Host read aborted by reset at bit 40
      @(negedge clk);
      req = 1'b1; req_we = 1'b0; req_phy = 2'd0; req_reg = 5'd1;
      k = 0;
      while (bitcnt != 40 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("abort_bit40_reached", bitcnt, 40);
      chk("abort_pre_oe", mdio_oe, 1);
      rst = 1'b1;
      #1;
      chk("abort_mdc", mdc, 0);
      chk("abort_mdio_oe", mdio_oe, 0);
      chk("abort_phy_rst", eth_phy_rst, 4'hF);
      req = 1'b0;
      repeat (3) @(negedge clk);
      reset_seq("again");
      chk("again_link", link_up, 4'b0000);
      chk("again_rdata", rdata, 16'h0000);
      repeat (10) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d failures",
               n_fail);
      $fatal(1);
   end

endmodule

// File: doc/eth_phy_mgmt.md
ETH_PHY_MGMT -- requirements
Module: eth_phy_mgmt

Interface
REQ-001 Parameter ETHCOUNT, 4, number of PHYs served (1..4).
REQ-002 Parameter CLK_DIV, 25, clk cycles per MDC half-period (125 MHz -> 2.5 MHz MDC).
REQ-003 Parameter RST_HOLD, 1250000, clk cycles eth_phy_rst held asserted (10 ms).
REQ-004 Parameter RST_WAIT, 625000, clk cycles after PHY reset release before first MDIO frame (5 ms).
REQ-005 Parameter POLL_CYCLES, 12500000, clk cycles between status-poll rounds (100 ms).
REQ-006 Parameter PHY_ADDR_BASE, 0, MDIO address of PHY index 0; PHY i at PHY_ADDR_BASE+i.
REQ-007 p_in_clk  in  1  single clock for all logic (mac_gtx_clk, 125 MHz).
REQ-008 p_in_rst  in  1  reset; asynchronous, active-high.
REQ-009 req  in  1  host register-access request; held until ack.
REQ-010 req_we  in  1  1 = write, 0 = read; valid with req.
REQ-011 req_phy  in  2  PHY index.
REQ-012 req_reg  in  5  PHY register address.
REQ-013 req_wdata  in  16  write data.
REQ-014 ack  out  1  one-cycle pulse, host access complete.
REQ-015 ack_err  out  1  valid with ack; 1 = req_phy >= ETHCOUNT.
REQ-016 rdata  out  16  read data, valid with ack, held until next ack.
REQ-017 link_up  out  ETHCOUNT  per-PHY link status from last poll (BMSR bit 2).
REQ-018 eth_phy_rst  out  ETHCOUNT  PHY reset, active-high, all bits driven together.
REQ-019 mdc  out  1  MDIO clock.
REQ-020 mdio_o / mdio_oe / mdio_i  out/out/in  1 each  MDIO tristate split; IOBUF in top level.
REQ-021 busy  out  1  high whenever state is not IDLE.

Function
REQ-022 States: RST_HOLD -> RST_WAIT -> IDLE <-> SHIFT -> DONE -> IDLE; RST_HOLD lasts RST_HOLD cycles, RST_WAIT lasts RST_WAIT cycles.
REQ-023 eth_phy_rst = 1 only in RST_HOLD; mdc = 0 and mdio_oe = 0 in RST_HOLD, RST_WAIT, IDLE, DONE.
REQ-024 Frame = 32 preamble ones, ST 01, OP (01 write / 10 read), PHYAD 5b, REGAD 5b, TA, 16 data bits, MSB first: 64 bits, 64 MDC periods = 128*CLK_DIV clk cycles.
REQ-025 mdio_o changes on MDC falling edge; read data sampled from mdio_i on MDC rising edge.
REQ-026 Write: mdio_oe = 1 for all 64 bits, TA = 10; read: mdio_oe = 1 for bits 0..45, 0 for TA and data.
REQ-027 Poll timer counts POLL_CYCLES from entering IDLE first time; on expiry sets poll_pending; round reads register 1 of PHY 0..ETHCOUNT-1 in order, one frame each, then clears poll_pending and restarts timer.
REQ-028 Arbitration in IDLE: if only one of req/poll_pending, serve it; if both, alternate, starting with host after reset; poll frames never preempt a frame in progress.
REQ-029 Poll read completion updates link_up[i] <= data[2] in DONE; host reads of register 1 do not update link_up.
REQ-030 Host access with req_phy >= ETHCOUNT: no frame; ack = 1, ack_err = 1, rdata = 16'hFFFF one cycle after acceptance.
REQ-031 Host access ack asserted in DONE, exactly one cycle; write ack rdata unchanged.
REQ-032 req arriving during RST_HOLD/RST_WAIT/SHIFT waits; inputs sampled at acceptance only.
REQ-033 Absent PHY (mdio_i pulled high) reads 16'hFFFF; no timeout, frame completes normally.

Reset
REQ-034 p_in_rst = 1 forces, asynchronously: state RST_HOLD, all counters 0, eth_phy_rst all 1, mdc 0, mdio_oe 0, mdio_o 1, ack 0, ack_err 0, rdata 0, link_up 0, poll_pending 0, arbitration pointer = host.
REQ-035 Reset mid-frame aborts the frame with no ack; full PHY reset sequence restarts on release.

Structure
REQ-036 Shared package eth_pkg holds: state enum, MDIO ST/OP constants, BMSR address (5'd1), link bit index (2), frame length (64).
REQ-037 One sub-module mdio_shifter: MDC divider plus 64-bit shift/sample engine, start/done handshake; controller holds FSM, poll timer, arbiter.

Verification (bench uses RST_HOLD=20, RST_WAIT=10, CLK_DIV=2, POLL_CYCLES=2000)
REQ-038 Release reset -> eth_phy_rst=1 for 20 cycles, 0 after; no MDC edge before cycle 30.
REQ-039 Host write phy 1, reg 0, data 16'h1140 -> MDIO bits 32x1, 01 01 00001 00000 10 0001000101000000; ack after 256 cycles.
REQ-040 Host read phy 2, reg 2, PHY model returns 16'h0141 -> rdata=16'h0141, mdio_oe=0 from bit 46.
REQ-041 Poll round, PHY models BMSR 16'h796D/16'h7949/16'h796D/16'hFFFF -> link_up=4'b1101.
REQ-042 req_phy=3 with ETHCOUNT=3 -> ack_err=1, rdata=16'hFFFF, no MDC activity.
REQ-043 Reset asserted at frame bit 40 -> mdc=0, mdio_oe=0 immediately, no ack, reset sequence repeats.
